// File: rtl/alu_mem_core.sv
// alu_mem_core: execute-stage core of the 32-bit master CPU.
// Holds a conditional ALU with a registered NZCV flag register, a data RAM
// used by LDR/STR and an instruction RAM loaded before fetch begins.
// Optional feature: define ALU_MUL_EN to turn opcode 12 into a signed MUL;
// without it opcode 12 behaves as NOP.
module alu_mem_core #(
  parameter int DATA_DEPTH  = 256,
  parameter int INSTR_DEPTH = 256
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               i_en,
  input  logic               i_rw,
  input  logic [15:0]        i_addr,
  input  logic [31:0]        i_din,
  output logic [31:0]        i_dout,
  input  logic               d_en,
  input  logic               d_rw,
  input  logic [15:0]        d_addr,
  input  logic [31:0]        d_din,
  output logic [31:0]        d_dout,
  input  logic signed [31:0] Reg1,
  input  logic signed [31:0] Reg2,
  input  logic [4:0]         IV_ShftRor,
  input  logic [15:0]        IV_Mov,
  input  logic [3:0]         OpCode,
  input  logic [3:0]         Cond,
  input  logic               S,
  output logic signed [31:0] Result,
  output logic [3:0]         Flag,
  output logic [3:0]         New_Flag,
  output logic               memory_enable,
  output logic               cond_pass
);

  localparam int DAW = $clog2(DATA_DEPTH);
  localparam int IAW = $clog2(INSTR_DEPTH);

  typedef enum logic [3:0] {
    OP_ADD = 4'd0,  OP_SUB = 4'd1,  OP_AND = 4'd2,  OP_ORR = 4'd3,
    OP_EOR = 4'd4,  OP_MOV = 4'd5,  OP_MOVI = 4'd6, OP_LSL = 4'd7,
    OP_LSR = 4'd8,  OP_ASR = 4'd9,  OP_ROR = 4'd10, OP_CMP = 4'd11,
    OP_MUL = 4'd12, OP_LDR = 4'd13, OP_STR = 4'd14, OP_NOP = 4'd15
  } op_e;

  // Memories: contents survive Reset, upper address bits wrap.
  logic [31:0] dmem [DATA_DEPTH];
  logic [31:0] imem [INSTR_DEPTH];

  // Only the low log2(DEPTH) address bits select a word.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{i_addr, d_addr};

  // Synchronous data RAM write port.
  always_ff @(posedge Clk) begin
    if (d_en && !d_rw) dmem[d_addr[DAW-1:0]] <= d_din;
  end

  // Synchronous instruction RAM write port.
  always_ff @(posedge Clk) begin
    if (i_en && !i_rw) imem[i_addr[IAW-1:0]] <= i_din;
  end

  assign d_dout = (d_en && d_rw) ? dmem[d_addr[DAW-1:0]] : 32'd0;
  assign i_dout = (i_en && i_rw) ? imem[i_addr[IAW-1:0]] : 32'd0;

  // Flag register {N,Z,C,V}.
  logic [3:0] flag_q, flag_d;
  logic       n_q, z_q, c_q, v_q;
  assign {n_q, z_q, c_q, v_q} = flag_q;

  // Condition code evaluation against the registered flags.
  always_comb begin
    cond_pass = 1'b0;
    case (Cond)
      4'd0:    cond_pass = z_q;
      4'd1:    cond_pass = !z_q;
      4'd2:    cond_pass = c_q;
      4'd3:    cond_pass = !c_q;
      4'd4:    cond_pass = n_q;
      4'd5:    cond_pass = !n_q;
      4'd6:    cond_pass = v_q;
      4'd7:    cond_pass = !v_q;
      4'd8:    cond_pass = c_q && !z_q;
      4'd9:    cond_pass = !c_q || z_q;
      4'd10:   cond_pass = (n_q == v_q);
      4'd11:   cond_pass = (n_q != v_q);
      4'd12:   cond_pass = !z_q && (n_q == v_q);
      4'd13:   cond_pass = z_q || (n_q != v_q);
      4'd14:   cond_pass = 1'b1;
      default: cond_pass = 1'b0;
    endcase
  end

  logic signed [31:0] alu_res;
  logic               c_new, v_new, upd, mem_op;
  logic [32:0]        sum_w, dif_w, lsl_w, lsr_w;
  logic signed [32:0] asr_w;
  logic               sh_zero;

  // Operation datapath; C comes from the extra bit carried beside each shift.
  always_comb begin
    alu_res = '0;
    c_new   = c_q;
    v_new   = v_q;
    upd     = 1'b0;
    mem_op  = 1'b0;
    sh_zero = (IV_ShftRor == 5'd0);
    sum_w   = {1'b0, Reg1} + {1'b0, Reg2};
    dif_w   = {1'b0, Reg1} - {1'b0, Reg2};
    lsl_w   = {1'b0, Reg1} << IV_ShftRor;
    lsr_w   = {Reg1, 1'b0} >> IV_ShftRor;
    asr_w   = $signed({Reg1, 1'b0}) >>> IV_ShftRor;
    case (OpCode)
      OP_ADD: begin
        alu_res = sum_w[31:0];
        c_new   = sum_w[32];
        v_new   = (Reg1[31] == Reg2[31]) && (sum_w[31] != Reg1[31]);
        upd     = 1'b1;
      end
      OP_SUB, OP_CMP: begin
        alu_res = dif_w[31:0];
        c_new   = !dif_w[32];
        v_new   = (Reg1[31] != Reg2[31]) && (dif_w[31] != Reg1[31]);
        upd     = 1'b1;
      end
      OP_AND:  begin alu_res = Reg1 & Reg2;       upd = 1'b1; end
      OP_ORR:  begin alu_res = Reg1 | Reg2;       upd = 1'b1; end
      OP_EOR:  begin alu_res = Reg1 ^ Reg2;       upd = 1'b1; end
      OP_MOV:  begin alu_res = Reg2;              upd = 1'b1; end
      OP_MOVI: begin alu_res = {16'd0, IV_Mov};   upd = 1'b1; end
      OP_LSL: begin
        alu_res = lsl_w[31:0];
        if (!sh_zero) c_new = lsl_w[32];
        upd = 1'b1;
      end
      OP_LSR: begin
        alu_res = lsr_w[32:1];
        if (!sh_zero) c_new = lsr_w[0];
        upd = 1'b1;
      end
      OP_ASR: begin
        alu_res = asr_w[32:1];
        if (!sh_zero) c_new = asr_w[0];
        upd = 1'b1;
      end
      OP_ROR: begin
        alu_res = (Reg1 >> IV_ShftRor) | (Reg1 << (6'd32 - {1'b0, IV_ShftRor}));
        if (!sh_zero) c_new = alu_res[31];
        upd = 1'b1;
      end
`ifdef ALU_MUL_EN
      OP_MUL: begin
        alu_res = Reg1 * Reg2;
        upd     = 1'b1;
      end
`else
      OP_MUL: alu_res = '0;
`endif
      OP_LDR, OP_STR: begin
        alu_res = Reg1 + {27'd0, IV_ShftRor};
        mem_op  = 1'b1;
      end
      default: alu_res = '0;
    endcase
  end

  // Gate everything by the condition and pick the next flag value.
  always_comb begin
    Result        = cond_pass ? alu_res : 32'sd0;
    memory_enable = cond_pass && mem_op;
    flag_d        = flag_q;
    if (cond_pass && upd && (S || (OpCode == OP_CMP)))
      flag_d = {alu_res[31], (alu_res == 32'sd0), c_new, v_new};
    New_Flag      = flag_d;
  end

  // Flag register update, cleared asynchronously by Reset.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) flag_q <= 4'b0000;
    else        flag_q <= flag_d;
  end

  assign Flag = flag_q;

endmodule

// File: tb/tb_alu_mem_core.sv
// Self-checking bench for alu_mem_core: directed RAM/ALU steps followed by
// randomized ALU traffic checked against an arithmetic reference model.
module tb_alu_mem_core;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        i_en, i_rw, d_en, d_rw, S;
  logic [15:0] i_addr, d_addr, IV_Mov;
  logic [31:0] i_din, i_dout, d_din, d_dout, Reg1, Reg2, Result;
  logic [4:0]  IV_ShftRor;
  logic [3:0]  OpCode, Cond, Flag, New_Flag;
  logic        memory_enable, cond_pass;

  int errors = 0;
  int checks = 0;
  logic [3:0] mflag;

  typedef struct packed {
    logic [31:0] res;
    logic [3:0]  nf;
    logic        me;
    logic        cp;
  } exp_t;

  alu_mem_core dut (
    .Clk(Clk), .Reset(Reset),
    .i_en(i_en), .i_rw(i_rw), .i_addr(i_addr), .i_din(i_din), .i_dout(i_dout),
    .d_en(d_en), .d_rw(d_rw), .d_addr(d_addr), .d_din(d_din), .d_dout(d_dout),
    .Reg1(Reg1), .Reg2(Reg2), .IV_ShftRor(IV_ShftRor), .IV_Mov(IV_Mov),
    .OpCode(OpCode), .Cond(Cond), .S(S),
    .Result(Result), .Flag(Flag), .New_Flag(New_Flag),
    .memory_enable(memory_enable), .cond_pass(cond_pass)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model built from the condition table and operation rules.
  function automatic exp_t model(input logic [3:0] fl, input logic [3:0] cnd,
                                 input logic [3:0] op, input logic s_b,
                                 input logic [31:0] a, input logic [31:0] b,
                                 input logic [4:0] sh, input logic [15:0] mv);
    exp_t e;
    logic n, z, c, v, pass, upd;
    logic [31:0] r, tmp;
    longint sa, sb, t, lim;
    longint unsigned ua, ub;
    int k;
    {n, z, c, v} = fl;
    sa = longint'($signed(a)); sb = longint'($signed(b));
    ua = a; ub = b; lim = 64'sd2147483647;
    k = int'(sh);
    r = 0; upd = 0; e.me = 0;
    case (cnd)
      0: pass = z;          1: pass = !z;
      2: pass = c;          3: pass = !c;
      4: pass = n;          5: pass = !n;
      6: pass = v;          7: pass = !v;
      8: pass = c && !z;    9: pass = !c || z;
      10: pass = n == v;    11: pass = n != v;
      12: pass = !z && n == v;
      13: pass = z || n != v;
      14: pass = 1;
      default: pass = 0;
    endcase
    case (op)
      0: begin t = sa + sb; r = a + b; c = (ua + ub) > 64'hFFFF_FFFF;
               v = (t > lim) || (t < -lim - 1); upd = 1; end
      1, 11: begin t = sa - sb; r = a - b; c = (a >= b);
               v = (t > lim) || (t < -lim - 1); upd = 1; end
      2: begin r = a & b; upd = 1; end
      3: begin r = a | b; upd = 1; end
      4: begin r = a ^ b; upd = 1; end
      5: begin r = b; upd = 1; end
      6: begin r = {16'h0, mv}; upd = 1; end
      7: begin r = a << k; upd = 1;
           if (k != 0) begin tmp = a >> (32 - k); c = tmp[0]; end end
      8: begin r = a >> k; upd = 1;
           if (k != 0) begin tmp = a >> (k - 1); c = tmp[0]; end end
      9: begin r = $signed(a) >>> k; upd = 1;
           if (k != 0) begin tmp = a >> (k - 1); c = tmp[0]; end end
      10: begin upd = 1;
            if (k == 0) r = a;
            else begin r = (a >> k) | (a << (32 - k)); c = r[31]; end end
`ifdef ALU_MUL_EN
      12: begin t = sa * sb; r = t[31:0]; upd = 1; end
`endif
      13, 14: begin r = a + 32'(k); e.me = 1; end
      default: r = 0;
    endcase
    e.cp = pass;
    if (!pass) begin
      e.res = 0; e.me = 0; e.nf = fl;
    end else begin
      e.res = r;
      e.nf = (upd && (s_b || op == 4'd11)) ? {r[31], r == 0, c, v} : fl;
    end
    return e;
  endfunction

  // One ALU instruction: drive, check combinational outputs, then the flag.
  task automatic alu(input logic [3:0] cnd, input logic [3:0] opc, input logic s_b,
                     input logic [31:0] a, input logic [31:0] b,
                     input logic [4:0] sh, input logic [15:0] mv);
    exp_t e;
    Cond = cnd; OpCode = opc; S = s_b; Reg1 = a; Reg2 = b;
    IV_ShftRor = sh; IV_Mov = mv;
    #4;
    e = model(mflag, cnd, opc, s_b, a, b, sh, mv);
    chk("result", Result, e.res);
    chk("new_flag", {28'd0, New_Flag}, {28'd0, e.nf});
    chk("mem_en", {31'd0, memory_enable}, {31'd0, e.me});
    chk("cond_pass", {31'd0, cond_pass}, {31'd0, e.cp});
    @(posedge Clk); #1;
    mflag = e.nf;
    chk("flag", {28'd0, Flag}, {28'd0, mflag});
  endtask

  function automatic logic [31:0] rnd_operand();
    case ($urandom_range(0, 5))
      0: return 32'h7FFF_FFFF;
      1: return 32'h8000_0000;
      2: return 32'($urandom_range(0, 7));
      3: return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  logic [31:0] dmodel [16];
  logic [31:0] mul_exp, a_r, b_r;

  initial begin
    Reset = 1'b0; mflag = 4'b0000;
    i_en = 0; i_rw = 1; i_addr = 0; i_din = 0;
    d_en = 0; d_rw = 1; d_addr = 0; d_din = 0;
    Reg1 = 0; Reg2 = 0; IV_ShftRor = 0; IV_Mov = 0; OpCode = 4'd15; Cond = 4'd14; S = 0;
    repeat (2) @(posedge Clk);
    #1;
    chk("reset_flag", {28'd0, Flag}, 32'd0);
    Reset = 1'b1;

    // Data RAM: write 0..7, read back, disabled read, aliasing.
    for (int i = 0; i < 8; i++) begin
      d_en = 1; d_rw = 0; d_addr = 16'(i); d_din = 32'hAAA0 + 32'(i);
      @(posedge Clk); #1;
    end
    d_rw = 1;
    for (int i = 0; i < 8; i++) begin
      d_addr = 16'(i); #1;
      chk("dram_read", d_dout, 32'hAAA0 + 32'(i));
    end
    d_en = 0; d_addr = 16'd3; #1;
    chk("dram_disabled", d_dout, 32'd0);
    d_en = 1; d_rw = 0; d_addr = 16'd5; #1;
    chk("dram_write_no_read", d_dout, 32'd0);
    d_rw = 1; d_addr = 16'h0100; #1;
    chk("dram_alias", d_dout, 32'hAAA0);
    // Random writes through aliased addresses, read back next cycle.
    for (int i = 0; i < 16; i++) dmodel[i] = 32'hAAA0 + 32'(i);
    for (int i = 0; i < 12; i++) begin
      int w;
      w = $urandom_range(0, 15);
      @(posedge Clk); #1;
      d_rw = 0; d_addr = 16'(w) | 16'($urandom_range(0, 255) << 8); d_din = $urandom;
      dmodel[w] = d_din;
      @(posedge Clk); #1;
      d_rw = 1; d_addr = 16'(w); #1;
      chk("dram_rand", d_dout, dmodel[w]);
    end
    d_en = 0;

    // Instruction RAM.
    @(posedge Clk); #1;
    i_en = 1; i_rw = 0; i_addr = 16'd3; i_din = 32'h1234_5678;
    @(posedge Clk); #1;
    i_rw = 1; #1;
    chk("iram_read", i_dout, 32'h1234_5678);
    i_addr = 16'h0203; #1;
    chk("iram_alias", i_dout, 32'h1234_5678);
    @(posedge Clk); #1;

    // Directed ALU cases.
    alu(4'd14, 4'd0, 1'b1, 32'h7FFF_FFFF, 32'd1, 5'd0, 16'd0);
    chk("add_ovf_result_flag", {24'd0, Flag, 4'd0}, {24'd0, 4'b1001, 4'd0});
    alu(4'd14, 4'd11, 1'b0, 32'd5, 32'd5, 5'd0, 16'd0);
    chk("cmp_eq_flag", {28'd0, Flag}, 32'b0110);
    alu(4'd0, 4'd1, 1'b0, 32'd5, 32'd5, 5'd0, 16'd0);
    chk("sub_eq_pass", {31'd0, Flag == 4'b0110}, 32'd1);
    alu(4'd1, 4'd1, 1'b1, 32'd9, 32'd2, 5'd0, 16'd0);
    chk("sub_ne_flag", {28'd0, Flag}, 32'b0110);
    Cond = 4'd14; OpCode = 4'd7; S = 1; Reg1 = 32'h8000_0001; IV_ShftRor = 5'd1; #1;
    chk("lsl_result", Result, 32'h0000_0002);
    @(posedge Clk); #1; mflag = Flag === 4'b0010 ? 4'b0010 : 4'bxxxx;
    chk("lsl_flag", {28'd0, Flag}, 32'b0010);
    mflag = 4'b0010;
    alu(4'd14, 4'd10, 1'b0, 32'h1, 32'd0, 5'd4, 16'd0);
    Cond = 4'd14; OpCode = 4'd10; S = 0; Reg1 = 32'h1; IV_ShftRor = 5'd4; #1;
    chk("ror_result", Result, 32'h1000_0000);
    @(posedge Clk); #1;
    Cond = 4'd14; OpCode = 4'd6; IV_Mov = 16'hBEEF; #1;
    chk("movi_result", Result, 32'h0000_BEEF);
    @(posedge Clk); #1;
    alu(4'd14, 4'd13, 1'b1, 32'd8, 32'd0, 5'd3, 16'd0);
    Cond = 4'd14; OpCode = 4'd13; S = 1; Reg1 = 32'd8; IV_ShftRor = 5'd3; #1;
    chk("ldr_result", Result, 32'd11);
    chk("ldr_mem_en", {31'd0, memory_enable}, 32'd1);
    @(posedge Clk); #1;
    chk("ldr_flag_kept", {28'd0, Flag}, 32'b0010);
`ifdef ALU_MUL_EN
    mul_exp = 32'hFFFF_FFF4;
`else
    mul_exp = 32'd0;
`endif
    alu(4'd14, 4'd12, 1'b0, 32'd3, 32'hFFFF_FFFC, 5'd0, 16'd0);
    Cond = 4'd14; OpCode = 4'd12; S = 0; Reg1 = 32'd3; Reg2 = 32'hFFFF_FFFC; #1;
    chk("mul_result", Result, mul_exp);
    @(posedge Clk); #1;
    alu(4'd15, 4'd0, 1'b1, 32'd1, 32'd1, 5'd0, 16'd0);
    alu(4'd14, 4'd8, 1'b1, 32'h8000_0000, 32'd0, 5'd0, 16'd0);

    // Reset mid-test: flags clear at once, RAM contents stay.
    alu(4'd14, 4'd1, 1'b1, 32'd0, 32'd1, 5'd0, 16'd0);
    Reset = 1'b0; #2;
    chk("async_reset_flag", {28'd0, Flag}, 32'd0);
    mflag = 4'b0000;
    i_addr = 16'd3; #1;
    chk("iram_after_reset", i_dout, 32'h1234_5678);
    @(posedge Clk); #1;
    Reset = 1'b1;
    i_en = 0;

    // Randomized ALU traffic.
    for (int i = 0; i < 300; i++) begin
      logic [3:0] cnd;
      a_r = rnd_operand();
      b_r = ($urandom_range(0, 4) == 0) ? a_r : rnd_operand();
      cnd = ($urandom_range(0, 1) == 0) ? 4'd14 : 4'($urandom_range(0, 15));
      alu(cnd, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), a_r, b_r,
          5'($urandom_range(0, 31)), 16'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
